issue_hazard_ctrl: RTL

Issue-stage controller between instruction fetch and the decoder. Holds a per-register busy scoreboard of in-flight destination writes, stalls fetch on RAW/WAW hazards or when the in-flight limit is reached, and presents the decoder with either the issued instruction or a bubble (bit 32 set). Scoreboard entries clear from the same 38-bit writeback bus the decoder uses to write its register file.

---
 rtl/issue_hazard_ctrl_if.sv | 21 ++
 rtl/issue_hazard_ctrl.sv | 88 ++++++++
 2 files changed

// File: rtl/issue_hazard_ctrl_if.sv
// Fetch/writeback/decoder signal bundle for the issue-stage hazard controller.
interface issue_hazard_ctrl_if;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        if_ready;
  logic [37:0] wb_bus;
  logic [32:0] dec_instr;
  logic [31:0] busy_map;
  logic [3:0]  inflight;
  logic [15:0] stall_cnt;

  modport master (
    output if_valid, if_instr, wb_bus,
    input  if_ready, dec_instr, busy_map, inflight, stall_cnt
  );

  modport slave (
    input  if_valid, if_instr, wb_bus,
    output if_ready, dec_instr, busy_map, inflight, stall_cnt
  );
endinterface

// File: rtl/issue_hazard_ctrl.sv
// Issue-stage scoreboard: blocks RAW/WAW hazards and caps in-flight writes,
// feeding the decoder either the issued instruction or a bubble.
module issue_hazard_ctrl #(
  parameter int unsigned MAX_INFL = 4
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  issue_hazard_ctrl_if.slave  io_bus
);

  localparam logic [32:0] Bubble = {1'b1, 32'h0};

  logic [32:0] r_dec_instr;
  logic [31:0] r_busy;
  logic [3:0]  r_inflight;
  logic [15:0] r_stall_cnt;

  logic [5:0]  w_opc;
  logic [4:0]  w_rs, w_rt, w_rd, w_dest, w_wb_addr;
  logic        w_rtype, w_rt_dest, w_rs_used, w_rt_used, w_dest_vld;
  logic        w_hazard, w_issue, w_set, w_clr, w_stall;
  logic [31:0] w_set_vec, w_clr_vec;
  logic        w_unused_wb;

  assign w_opc     = io_bus.if_instr[31:26];
  assign w_rs      = io_bus.if_instr[25:21];
  assign w_rt      = io_bus.if_instr[20:16];
  assign w_rd      = io_bus.if_instr[15:11];
  assign w_wb_addr = io_bus.wb_bus[4:0];
  assign w_unused_wb = ^io_bus.wb_bus[36:5];

  always_comb begin
    w_rtype   = 1'b0;
    w_rt_dest = 1'b0;
    case (w_opc)
      6'b000000, 6'b000001, 6'b000101, 6'b000110,
      6'b000111, 6'b000011, 6'b000100: w_rtype   = 1'b1;
      6'b001011, 6'b000010, 6'b100011: w_rt_dest = 1'b1;
      default: ;
    endcase
  end

  assign w_rs_used  = (w_opc != 6'b000010);
  assign w_rt_used  = w_rtype | (w_opc == 6'b101011);
  assign w_dest     = w_rtype ? w_rd : w_rt;
  assign w_dest_vld = (w_rtype | w_rt_dest) & (w_dest != 5'd0);

  // Only registered state feeds the hazard check; wb_bus never reaches if_ready.
  assign w_hazard = (w_rs_used  & (w_rs != 5'd0) & r_busy[w_rs])
                  | (w_rt_used  & (w_rt != 5'd0) & r_busy[w_rt])
                  | (w_dest_vld & r_busy[w_dest])
                  | (w_dest_vld & (r_inflight == 4'(MAX_INFL)));

  assign w_issue = io_bus.if_valid & ~w_hazard;
  assign w_stall = io_bus.if_valid & w_hazard;
  assign w_set   = w_issue & w_dest_vld;
  assign w_clr   = io_bus.wb_bus[37] & (w_wb_addr != 5'd0) & r_busy[w_wb_addr];

  assign w_set_vec = w_set ? (32'h1 << w_dest)    : 32'h0;
  assign w_clr_vec = w_clr ? (32'h1 << w_wb_addr) : 32'h0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dec_instr <= Bubble;
      r_busy      <= 32'h0;
      r_inflight  <= 4'd0;
      r_stall_cnt <= 16'h0;
    end else begin
      r_dec_instr <= w_issue ? {1'b0, io_bus.if_instr} : Bubble;
      r_busy      <= (r_busy & ~w_clr_vec) | w_set_vec;
      if (w_set && !w_clr) begin
        r_inflight <= r_inflight + 4'd1;
      end else if (!w_set && w_clr) begin
        r_inflight <= r_inflight - 4'd1;
      end
      if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign io_bus.if_ready  = w_issue;
  assign io_bus.dec_instr = r_dec_instr;
  assign io_bus.busy_map  = r_busy;
  assign io_bus.inflight  = r_inflight;
  assign io_bus.stall_cnt = r_stall_cnt;

endmodule
